regfile_alu_pipe: RTL
=====================

// Module: regfile_alu_pipe
// PURPOSE
//  Single-issue ALU plus write-back stage that sits directly upstream of the 8x8 register file.
//  It accepts one instruction per cycle over a valid/ready handshake.
//  It reads operands through the register file's asynchronous read ports and computes the result.
//  It drives the register file write port (we/waddr/wdata) one cycle later, with WB->EX forwarding.
// PARAMETERS
//  DW     8   data width; matches register file word width
//  AW     3   register address width (2**AW registers)
//  CNT_W  16  width of the retired-instruction counter
// PORTS
//  clk         in   1      rising-edge clock
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      instruction present on in_* this cycle
//  in_ready    out  1      block can accept; = ~hold (combinational)
//  in_op       in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 LDI
//  in_rd       in   AW     destination register
//  in_rs1      in   AW     source A register
//  in_rs2      in   AW     source B register
//  in_imm      in   DW     immediate; used only by LDI
//  hold        in   1      freeze: no commit, no accept
//  raddr1      out  AW     = in_rs1 (combinational) to register file read port 1
//  raddr2      out  AW     = in_rs2 (combinational) to register file read port 2
//  rdata1      in   DW     register file read data 1 (async read)
//  rdata2      in   DW     register file read data 2 (async read)
//  we          out  1      register file write enable; = wb_valid & ~hold
//  waddr       out  AW     registered destination address
//  wdata       out  DW     registered result
//  flag_z      out  1      zero flag of last committed non-LDI op
//  flag_c      out  1      carry/borrow flag of last committed non-LDI op
//  retire_cnt  out  CNT_W  commits since reset; saturates at all-ones
// BEHAVIOUR
//  Reset (reset_n=0, async): wb_valid=0, waddr=0, wdata=0, flag_z=0, flag_c=0, retire_cnt=0.
//   Hence we=0 immediately, mid-operation included; a pending write is dropped.
//  accept = in_valid & in_ready.
//  commit = we; the register file captures the write at the same rising edge.
//  Operand select:
//   A = (we && waddr==in_rs1) ? wdata : rdata1.
//   B = (we && waddr==in_rs2) ? wdata : rdata2.
//   Forwarding is needed because the register file write lands only at the end of the commit cycle.
//  ALU: all ops are DW-bit and wrap modulo 2**DW.
//   ADD: c = carry-out of A+B.
//   SUB: A-B; c = borrow (A<B unsigned).
//   AND, OR, XOR: c = 0.
//   SHL1: A<<1; c = A[DW-1].
//   SHR1: A>>1 logical; c = A[0].
//   LDI: result = in_imm; flags not updated.
//   z = (result==0).
//  Pipeline, 1-cycle latency: accept in cycle N -> wb_valid=1, waddr=in_rd, wdata=result in cycle N+1.
//   Staged z/c are captured in the same cycle.
//  Edge with commit and no accept: wb_valid <= 0.
//  Edge with commit and accept together: the WB stage reloads with the new op; back-to-back throughput is 1/cycle.
//  hold=1: WB registers keep their value, we=0, in_ready=0, and in_valid is ignored.
//   After hold falls, the pending op commits exactly once.
//  On commit: flag_z/flag_c <= staged flags (unless LDI); retire_cnt += 1 unless already all-ones.
//  rd==rs1==rs2 is legal; forwarding applies to each operand independently.
//  Writes to any register, including r0, are ordinary writes.
// TESTING
//  1. Reset then LDI r1,0x7F; next cycle ADD r2,r1,r1 -> we=1 waddr=1 wdata=0x7F, then waddr=2 wdata=0xFE (forwarded), z=0, c=0.
//  2. r1=0x7F, r0=0; SUB r3,r1,r1 -> wdata=0x00, z=1, c=0; then SUB r4,r0,r1 -> wdata=0x81, c=1, z=0.
//  3. LDI r5,0x80; SHL1 r6,r5 -> wdata=0x00, c=1, z=1; SHR1 r7,r5 -> wdata=0x40, c=0.
//  4. Op pending, hold=1 for 3 cycles -> we=0, in_ready=0, wdata stable, retire_cnt unchanged; release -> one commit, retire_cnt +1.
//  5. reset_n pulsed low between clock edges while we=1 -> we, wdata and retire_cnt go to 0 before the next edge; the register file is unchanged.
//  6. CNT_W=4, 20 back-to-back LDI r0..r7 (wrapping) -> retire_cnt=15; register file readback equals the last immediate per register.

Source files
------------

// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_pipe
// Purpose  : Single-issue ALU with one write-back stage feeding an 8x8
//            register file, with WB->EX operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_pipe #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [DW-1:0]    in_imm,
    input  logic             hold,
    output logic [AW-1:0]    raddr1,
    output logic [AW-1:0]    raddr2,
    input  logic [DW-1:0]    rdata1,
    input  logic [DW-1:0]    rdata2,
    output logic             we,
    output logic [AW-1:0]    waddr,
    output logic [DW-1:0]    wdata,
    output logic             flag_z,
    output logic             flag_c,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_AND  = 3'd2;
    localparam logic [2:0] c_OP_OR   = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_SHL1 = 3'd5;
    localparam logic [2:0] c_OP_SHR1 = 3'd6;
    localparam logic [2:0] c_OP_LDI  = 3'd7;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // write-back stage state
    logic             wb_valid_q, wb_valid_d;
    logic [AW-1:0]    waddr_q,    waddr_d;
    logic [DW-1:0]    wdata_q,    wdata_d;
    logic             stg_z_q,    stg_z_d;
    logic             stg_c_q,    stg_c_d;
    logic             stg_ldi_q,  stg_ldi_d;
    logic             flag_z_q,   flag_z_d;
    logic             flag_c_q,   flag_c_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic          w_accept;
    logic          w_commit;
    logic [DW-1:0] w_opa;
    logic [DW-1:0] w_opb;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_result;
    logic          w_c;
    logic          w_z;

    assign in_ready = ~hold;
    assign w_accept = in_valid & ~hold;
    assign w_commit = wb_valid_q & ~hold;

    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;

    assign we         = w_commit;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign retire_cnt = retire_cnt_q;

    // The register file write lands at the end of the commit cycle, so the
    // committing value must bypass the stale async read data.
    assign w_opa = (w_commit && (waddr_q == in_rs1)) ? wdata_q : rdata1;
    assign w_opb = (w_commit && (waddr_q == in_rs2)) ? wdata_q : rdata2;

    // Borrow of the subtraction falls out as the top bit of the wide difference.
    assign w_sum  = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_diff = {1'b0, w_opa} - {1'b0, w_opb};

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        case (in_op)
            c_OP_ADD: begin
                w_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
            end
            c_OP_SUB: begin
                w_result = w_diff[DW-1:0];
                w_c      = w_diff[DW];
            end
            c_OP_AND: w_result = w_opa & w_opb;
            c_OP_OR:  w_result = w_opa | w_opb;
            c_OP_XOR: w_result = w_opa ^ w_opb;
            c_OP_SHL1: begin
                w_result = {w_opa[DW-2:0], 1'b0};
                w_c      = w_opa[DW-1];
            end
            c_OP_SHR1: begin
                w_result = {1'b0, w_opa[DW-1:1]};
                w_c      = w_opa[0];
            end
            c_OP_LDI: w_result = in_imm;
            default: begin
                w_result = '0;
                w_c      = 1'b0;
            end
        endcase
    end

    assign w_z = (w_result == '0);

    always_comb begin
        wb_valid_d   = wb_valid_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        stg_z_d      = stg_z_q;
        stg_c_d      = stg_c_q;
        stg_ldi_d    = stg_ldi_q;
        flag_z_d     = flag_z_q;
        flag_c_d     = flag_c_q;
        retire_cnt_d = retire_cnt_q;

        if (w_accept) begin
            wb_valid_d = 1'b1;
            waddr_d    = in_rd;
            wdata_d    = w_result;
            stg_z_d    = w_z;
            stg_c_d    = w_c;
            stg_ldi_d  = (in_op == c_OP_LDI);
        end else if (w_commit) begin
            wb_valid_d = 1'b0;
        end

        if (w_commit) begin
            if (!stg_ldi_q) begin
                flag_z_d = stg_z_q;
                flag_c_d = stg_c_q;
            end
            if (retire_cnt_q != c_CNT_MAX) begin
                retire_cnt_d = retire_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q   <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            stg_z_q      <= 1'b0;
            stg_c_q      <= 1'b0;
            stg_ldi_q    <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            stg_z_q      <= stg_z_d;
            stg_c_q      <= stg_c_d;
            stg_ldi_q    <= stg_ldi_d;
            flag_z_q     <= flag_z_d;
            flag_c_q     <= flag_c_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule
`default_nettype wire
